uart_rx_frame_ctrl: RTL and testbench
=====================================

Name: uart_rx_frame_ctrl

Overview:
Sequencer that sits behind uart_rx and turns its byte stream into validated command frames. Frame format: SYNC, CMD, ADDR, LEN, LEN payload bytes, CSUM. The block hunts for SYNC, buffers the payload and verifies the checksum. Good frames go out as a header handshake followed by a payload stream; bad frames are dropped and counted.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker
MAX_LEN, 16, maximum payload bytes (1..255)
TIMEOUT_CYC, 8680, idle clocks allowed between bytes inside a frame (10 bit-times at 868 clk/bit)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_byte_data  in  8  byte from uart_rx
rx_byte_valid  in  1  one-cycle byte strobe from uart_rx
par_error  in  1  parity error pulse from uart_rx
stop_error  in  1  stop error pulse from uart_rx
frm_valid  out  1  header valid
frm_ready  in  1  header accept
frm_cmd  out  8  CMD field
frm_addr  out  8  ADDR field
frm_len  out  8  LEN field
pl_valid  out  1  payload beat valid
pl_ready  in  1  payload beat accept
pl_data  out  8  payload byte
pl_last  out  1  final payload beat
clr_cnt  in  1  synchronous clear of all counters
err_csum_cnt, err_len_cnt, err_tmo_cnt, err_line_cnt, ovr_cnt  out  8 each  saturating event counters

Behaviour:
- Reset is asynchronous and active-low (rst_n). Clock is clk. On reset: state HUNT; all outputs 0; counters 0; payload buffer contents don't-care.
- States: HUNT, CMD, ADDR, LEN, PAYLOAD, CSUM, CHECK, OUT_HDR, OUT_PL.
- HUNT: a byte equal to SYNC_BYTE goes to CMD. Any other byte is ignored and not counted. Error pulses in HUNT are ignored.
- CMD, ADDR, LEN: each captures one byte on rx_byte_valid and advances.
  - LEN > MAX_LEN: go to HUNT, increment err_len_cnt.
  - LEN == 0: go to CSUM.
  - Otherwise: go to PAYLOAD.
- PAYLOAD: writes byte i to buf[i]. After LEN bytes, go to CSUM.
- CSUM: running sum is 8-bit modulo-256 over CMD, ADDR, LEN, payload and CSUM. On the CSUM byte, go to CHECK.
- CHECK: lasts one cycle.
  - Sum == 0: go to OUT_HDR.
  - Otherwise: go to HUNT and increment err_csum_cnt.
- Latency: CSUM byte strobe at cycle T means frm_valid is high at T+2.
- OUT_HDR: frm_valid = 1, with frm_cmd, frm_addr and frm_len stable until frm_valid & frm_ready.
  - On accept with LEN == 0: go to HUNT.
  - On accept otherwise: go to OUT_PL with rd_idx = 0.
- OUT_PL: pl_valid = 1 and pl_data = buf[rd_idx] (combinational read). pl_last = (rd_idx == LEN-1).
  - On pl_valid & pl_ready: rd_idx increments.
  - Accept with pl_last: go to HUNT.
  - Header and payload stalls are unbounded.
- Line errors: par_error or stop_error in CMD through CSUM aborts to HUNT and increments err_line_cnt. If an error pulse and a byte strobe share a cycle, the error wins and the byte is discarded.
- Timeout: in CMD through CSUM, an idle counter counts clocks since the last byte.
  - Reaching TIMEOUT_CYC aborts to HUNT and increments err_tmo_cnt.
  - A byte in the expiry cycle wins and reloads the counter.
  - Counter width is $clog2(TIMEOUT_CYC+1).
- Overrun: a byte strobe in CHECK, OUT_HDR or OUT_PL is dropped and increments ovr_cnt. Bytes received in these states are never used for SYNC detection.
- Mid-frame SYNC_BYTE is ordinary data; there is no resync.
- Counters saturate at 255. clr_cnt wins over a simultaneous increment.
- Only one counter event can occur per cycle, except overrun combined with nothing else.
- Reset asserted mid-frame or mid-output discards the frame immediately; no partial outputs.

Decomposition:
- Package uart_pkg holds:
  - frame_state_t enum
  - default SYNC_BYTE constant
  - CNT_W = 8 constant
  - checksum width constant
- Sub-module sat_counter (CNT_W width, inc, clr, async rst_n, saturating) is instantiated five times.
- Payload buffer is a register array inside the top module.

Test Plan:
- Good frame: bytes A5 10 20 02 11 22 9B with frm_ready and pl_ready held at 1 -> frm_valid two cycles after the 9B strobe, header 10/20/02; payload beats 11 then 22 with pl_last on 22; all counters 0.
- Zero-length frame: A5 01 02 00 FD -> single header 01/02/00; no pl_valid; state returns to HUNT.
- Checksum and length errors:
  - A5 10 20 02 11 22 9C -> no frm_valid, err_csum_cnt = 1.
  - A5 01 02 20 (MAX_LEN = 16) -> abort at LEN, err_len_cnt = 1; the following good frame is still received.
- Line error and timeout:
  - par_error pulse after the first payload byte -> err_line_cnt = 1.
  - A5 10 then silence for TIMEOUT_CYC clocks -> err_tmo_cnt = 1.
  - Both cases: back in HUNT with no frm_valid.
- Backpressure and overrun: good frame with frm_ready = 0 for 3000 cycles while two bytes arrive -> ovr_cnt = 2; header then delivered intact once frm_ready rises.
- Saturation, clear and reset: 260 bad-checksum frames -> err_csum_cnt = 255; clr_cnt in the same cycle as a 261st error -> 0. rst_n low during OUT_PL -> outputs 0 asynchronously, state HUNT.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive frame sequencer.
package uart_pkg;

  typedef enum logic [3:0] {
    S_HUNT,
    S_CMD,
    S_ADDR,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_CHECK,
    S_OUT_HDR,
    S_OUT_PL
  } frame_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         CNT_W         = 8;
  localparam int         CSUM_W        = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; synchronous clear has priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_cnt <= '0;
    else if (i_clr)                  r_cnt <= '0;
    else if (i_inc && r_cnt != '1)   r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Hunts for SYNC, buffers and checksums a command frame, then emits header + payload.
// Malformed, timed-out or line-corrupted frames are dropped and counted.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 8680
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_byte_data,
  input  logic             rx_byte_valid,
  input  logic             par_error,
  input  logic             stop_error,
  output logic             frm_valid,
  input  logic             frm_ready,
  output logic [7:0]       frm_cmd,
  output logic [7:0]       frm_addr,
  output logic [7:0]       frm_len,
  output logic             pl_valid,
  input  logic             pl_ready,
  output logic [7:0]       pl_data,
  output logic             pl_last,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] err_csum_cnt,
  output logic [CNT_W-1:0] err_len_cnt,
  output logic [CNT_W-1:0] err_tmo_cnt,
  output logic [CNT_W-1:0] err_line_cnt,
  output logic [CNT_W-1:0] ovr_cnt
);

  localparam int                IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int                TMO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]        MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

  frame_state_t        r_state;
  logic [7:0]          r_cmd, r_addr, r_len;
  logic [CSUM_W-1:0]   r_sum;
  logic [7:0]          r_wr_idx, r_rd_idx;
  logic [TMO_W-1:0]    r_idle;
  logic                r_frm_valid, r_pl_valid;
  logic [7:0]          r_buf [MAX_LEN];

  logic w_in_frame, w_line_err, w_byte, w_tmo, w_len_err, w_pl_last;
  logic [4:0]            w_inc;
  logic [4:0][CNT_W-1:0] w_cnt;

  always_comb begin
    w_in_frame = r_state inside {S_CMD, S_ADDR, S_LEN, S_PAYLOAD, S_CSUM};
    // A line error in the same cycle as a strobe kills the byte.
    w_line_err = w_in_frame && (par_error || stop_error);
    w_byte     = w_in_frame && rx_byte_valid && !w_line_err;
    w_tmo      = w_in_frame && !rx_byte_valid && !w_line_err && (r_idle == TMO_LAST);
    w_len_err  = (r_state == S_LEN) && w_byte && (rx_byte_data > MAX_LEN_B);
    w_pl_last  = r_pl_valid && (r_rd_idx == r_len - 8'd1);
    w_inc[0]   = (r_state == S_CHECK) && (r_sum != '0);
    w_inc[1]   = w_len_err;
    w_inc[2]   = w_tmo;
    w_inc[3]   = w_line_err;
    w_inc[4]   = rx_byte_valid && (r_state inside {S_CHECK, S_OUT_HDR, S_OUT_PL});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_HUNT;
      r_cmd       <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_sum       <= '0;
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_idle      <= '0;
      r_frm_valid <= 1'b0;
      r_pl_valid  <= 1'b0;
    end else begin
      if (w_in_frame) r_idle <= w_byte ? '0 : r_idle + TMO_W'(1);
      case (r_state)
        S_HUNT: begin
          r_idle <= '0;
          r_sum  <= '0;
          if (rx_byte_valid && rx_byte_data == SYNC_BYTE) r_state <= S_CMD;
        end
        S_CMD, S_ADDR, S_LEN, S_PAYLOAD, S_CSUM: begin
          if (w_line_err || w_tmo) r_state <= S_HUNT;
          else if (w_byte) begin
            r_sum <= r_sum + rx_byte_data;
            case (r_state)
              S_CMD:  begin r_cmd  <= rx_byte_data; r_state <= S_ADDR; end
              S_ADDR: begin r_addr <= rx_byte_data; r_state <= S_LEN;  end
              S_LEN: begin
                r_len    <= rx_byte_data;
                r_wr_idx <= '0;
                if (w_len_err)               r_state <= S_HUNT;
                else if (rx_byte_data == '0) r_state <= S_CSUM;
                else                         r_state <= S_PAYLOAD;
              end
              S_PAYLOAD: begin
                r_wr_idx <= r_wr_idx + 8'd1;
                if (r_wr_idx == r_len - 8'd1) r_state <= S_CSUM;
              end
              default: r_state <= S_CHECK;
            endcase
          end
        end
        S_CHECK: begin
          if (r_sum == '0) begin
            r_state     <= S_OUT_HDR;
            r_frm_valid <= 1'b1;
          end else begin
            r_state <= S_HUNT;
          end
        end
        S_OUT_HDR: begin
          if (frm_ready) begin
            r_frm_valid <= 1'b0;
            r_rd_idx    <= '0;
            if (r_len == '0) r_state <= S_HUNT;
            else begin
              r_state    <= S_OUT_PL;
              r_pl_valid <= 1'b1;
            end
          end
        end
        S_OUT_PL: begin
          if (pl_ready) begin
            if (w_pl_last) begin
              r_pl_valid <= 1'b0;
              r_state    <= S_HUNT;
            end else begin
              r_rd_idx <= r_rd_idx + 8'd1;
            end
          end
        end
        default: r_state <= S_HUNT;
      endcase
    end
  end

  // Payload storage is not reset; contents only matter after a full frame lands.
  always_ff @(posedge clk) begin
    if (r_state == S_PAYLOAD && w_byte) r_buf[r_wr_idx[IDX_W-1:0]] <= rx_byte_data;
  end

  for (genvar g = 0; g < 5; g++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_inc[g]),
      .i_clr (clr_cnt),
      .o_cnt (w_cnt[g])
    );
  end

  assign frm_valid    = r_frm_valid;
  assign frm_cmd      = r_cmd;
  assign frm_addr     = r_addr;
  assign frm_len      = r_len;
  assign pl_valid     = r_pl_valid;
  assign pl_data      = r_pl_valid ? r_buf[r_rd_idx[IDX_W-1:0]] : 8'h00;
  assign pl_last      = w_pl_last;
  assign err_csum_cnt = w_cnt[0];
  assign err_len_cnt  = w_cnt[1];
  assign err_tmo_cnt  = w_cnt[2];
  assign err_line_cnt = w_cnt[3];
  assign ovr_cnt      = w_cnt[4];

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: expected headers/beats queued at send time.
module tb_uart_rx_frame_ctrl;

  localparam int TMO = 8680;

  logic       clk, rst_n;
  logic [7:0] rx_byte_data;
  logic       rx_byte_valid, par_error, stop_error;
  logic       frm_valid, frm_ready, pl_valid, pl_ready, pl_last, clr_cnt;
  logic [7:0] frm_cmd, frm_addr, frm_len, pl_data;
  logic [7:0] err_csum_cnt, err_len_cnt, err_tmo_cnt, err_line_cnt, ovr_cnt;

  uart_rx_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rx_byte_data(rx_byte_data), .rx_byte_valid(rx_byte_valid),
    .par_error(par_error), .stop_error(stop_error), .frm_valid(frm_valid), .frm_ready(frm_ready),
    .frm_cmd(frm_cmd), .frm_addr(frm_addr), .frm_len(frm_len), .pl_valid(pl_valid),
    .pl_ready(pl_ready), .pl_data(pl_data), .pl_last(pl_last), .clr_cnt(clr_cnt),
    .err_csum_cnt(err_csum_cnt), .err_len_cnt(err_len_cnt), .err_tmo_cnt(err_tmo_cnt),
    .err_line_cnt(err_line_cnt), .ovr_cnt(ovr_cnt)
  );

  int errors = 0;
  int checks = 0;
  logic [23:0] hdr_q [$];
  logic [8:0]  pl_q  [$];
  logic [7:0]  pbuf  [16];
  logic [7:0]  exp_csum = 0, exp_len = 0, exp_tmo = 0, exp_line = 0, exp_ovr = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: every handshake must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frm_valid && frm_ready) begin
        checks++;
        if (hdr_q.size() == 0) begin
          errors++;
          $display("FAIL hdr_unexpected got %h exp none", {frm_cmd, frm_addr, frm_len});
        end else begin
          logic [23:0] eh;
          eh = hdr_q.pop_front();
          if ({frm_cmd, frm_addr, frm_len} !== eh) begin
            errors++;
            $display("FAIL hdr got %h exp %h", {frm_cmd, frm_addr, frm_len}, eh);
          end
        end
      end
      if (pl_valid && pl_ready) begin
        checks++;
        if (pl_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected got %h exp none", {pl_last, pl_data});
        end else begin
          logic [8:0] ep;
          ep = pl_q.pop_front();
          if ({pl_last, pl_data} !== ep) begin
            errors++;
            $display("FAIL beat got last/data %h exp %h", {pl_last, pl_data}, ep);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_byte_data  = b;
    rx_byte_valid = 1'b1;
    @(posedge clk); #1;
    rx_byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] len,
                            input logic corrupt, input logic expect_ok);
    logic [7:0] sum;
    sum = cmd + addr + len;
    send_byte(8'hA5); send_byte(cmd); send_byte(addr); send_byte(len);
    for (int i = 0; i < int'(len); i++) begin
      send_byte(pbuf[i]);
      sum = sum + pbuf[i];
    end
    if (expect_ok) begin
      hdr_q.push_back({cmd, addr, len});
      for (int i = 0; i < int'(len); i++) pl_q.push_back({(i == int'(len) - 1), pbuf[i]});
    end
    send_byte(8'h00 - sum + {7'd0, corrupt});
  endtask

  task automatic wait_drain(input bit rnd);
    int n = 0;
    while ((hdr_q.size() != 0 || pl_q.size() != 0) && n < 2000) begin
      if (rnd) pl_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    pl_ready = 1'b1;
    checks++;
    if (hdr_q.size() != 0 || pl_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout hdr_left=%0d beats_left=%0d exp 0", hdr_q.size(), pl_q.size());
      hdr_q.delete(); pl_q.delete();
    end
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({frm_valid, pl_valid, pl_last, pl_data, frm_cmd, frm_addr, frm_len,
         err_csum_cnt, err_len_cnt, err_tmo_cnt, err_line_cnt, ovr_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b%b cnt=%h exp all 0", frm_valid, pl_valid,
               {err_csum_cnt, err_len_cnt, err_tmo_cnt, err_line_cnt, ovr_cnt});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_good_frame;
    send_byte(8'h00); send_byte(8'h5A);
    pbuf[0] = 8'h11; pbuf[1] = 8'h22;
    send_frame(8'h10, 8'h20, 8'h02, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (frm_valid !== 1'b0) begin errors++; $display("FAIL latency_t1 got %b exp 0", frm_valid); end
    @(negedge clk);
    checks++;
    if (frm_valid !== 1'b1) begin errors++; $display("FAIL latency_t2 got %b exp 1", frm_valid); end
    wait_drain(0);
    checks++;
    if ({err_csum_cnt, err_len_cnt, err_tmo_cnt, err_line_cnt, ovr_cnt} !== 40'd0) begin
      errors++;
      $display("FAIL good_counters got %h exp 0", {err_csum_cnt, err_len_cnt, err_tmo_cnt, err_line_cnt, ovr_cnt});
    end
  endtask

  task automatic test_zero_len;
    send_frame(8'h01, 8'h02, 8'h00, 1'b0, 1'b1);
    wait_drain(0);
    send_frame(8'h03, 8'h04, 8'h00, 1'b0, 1'b1);
    wait_drain(0);
  endtask

  task automatic test_csum_len_err;
    pbuf[0] = 8'h11; pbuf[1] = 8'h22;
    send_frame(8'h10, 8'h20, 8'h02, 1'b1, 1'b0);
    exp_csum++;
    repeat (4) @(posedge clk); #1;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h20);
    exp_len++;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h11);
    exp_len++;
    pbuf[0] = 8'hA5; pbuf[1] = 8'h00; pbuf[2] = 8'hFF;
    send_frame(8'h01, 8'h02, 8'h03, 1'b0, 1'b1);
    wait_drain(0);
    checks++;
    if ({err_csum_cnt, err_len_cnt, err_tmo_cnt, err_line_cnt, ovr_cnt} !==
        {exp_csum, exp_len, exp_tmo, exp_line, exp_ovr}) begin
      errors++;
      $display("FAIL csum_len_counters got %h exp %h", {err_csum_cnt, err_len_cnt, err_tmo_cnt, err_line_cnt, ovr_cnt},
               {exp_csum, exp_len, exp_tmo, exp_line, exp_ovr});
    end
  endtask

  task automatic test_line_err;
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h20); send_byte(8'h02); send_byte(8'h11);
    par_error = 1'b1;
    @(posedge clk); #1;
    par_error = 1'b0;
    exp_line++;
    send_byte(8'h22); send_byte(8'h9B);
    send_byte(8'hA5);
    stop_error = 1'b1;
    send_byte(8'h10);
    stop_error = 1'b0;
    exp_line++;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({err_csum_cnt, err_len_cnt, err_tmo_cnt, err_line_cnt, ovr_cnt} !==
        {exp_csum, exp_len, exp_tmo, exp_line, exp_ovr}) begin
      errors++;
      $display("FAIL line_counters got %h exp %h", {err_csum_cnt, err_len_cnt, err_tmo_cnt, err_line_cnt, ovr_cnt},
               {exp_csum, exp_len, exp_tmo, exp_line, exp_ovr});
    end
    pbuf[0] = 8'h42;
    send_frame(8'h07, 8'h08, 8'h01, 1'b0, 1'b1);
    wait_drain(0);
  endtask

  task automatic test_timeout;
    send_byte(8'hA5); send_byte(8'h10);
    repeat (TMO - 1) @(posedge clk);
    @(negedge clk);
    checks++;
    if (err_tmo_cnt !== exp_tmo) begin errors++; $display("FAIL tmo_early got %0d exp %0d", err_tmo_cnt, exp_tmo); end
    exp_tmo++;
    @(negedge clk);
    checks++;
    if (err_tmo_cnt !== exp_tmo) begin errors++; $display("FAIL tmo_expire got %0d exp %0d", err_tmo_cnt, exp_tmo); end
    @(posedge clk); #1;
    // A byte landing exactly in the expiry cycle keeps the frame alive.
    send_byte(8'hA5); send_byte(8'h10);
    repeat (TMO - 1) @(posedge clk);
    #1;
    hdr_q.push_back(24'h102002);
    pl_q.push_back(9'h011); pl_q.push_back(9'h122);
    send_byte(8'h20); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22); send_byte(8'h9B);
    wait_drain(0);
    checks++;
    if ({err_csum_cnt, err_len_cnt, err_tmo_cnt, err_line_cnt, ovr_cnt} !==
        {exp_csum, exp_len, exp_tmo, exp_line, exp_ovr}) begin
      errors++;
      $display("FAIL tmo_counters got %h exp %h", {err_csum_cnt, err_len_cnt, err_tmo_cnt, err_line_cnt, ovr_cnt},
               {exp_csum, exp_len, exp_tmo, exp_line, exp_ovr});
    end
  endtask

  task automatic test_backpressure;
    int n;
    frm_ready = 1'b0;
    pbuf[0] = 8'h01; pbuf[1] = 8'h02; pbuf[2] = 8'h03;
    send_frame(8'h33, 8'h44, 8'h03, 1'b0, 1'b1);
    repeat (1000) @(posedge clk); #1;
    send_byte(8'hA5);
    repeat (1000) @(posedge clk); #1;
    send_byte(8'h5A);
    exp_ovr += 2;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({frm_valid, frm_cmd, frm_addr, frm_len} !== {1'b1, 24'h334403}) begin
      errors++;
      $display("FAIL hdr_hold got %h exp %h", {frm_valid, frm_cmd, frm_addr, frm_len}, {1'b1, 24'h334403});
    end
    checks++;
    if (ovr_cnt !== exp_ovr) begin errors++; $display("FAIL ovr_hdr got %0d exp %0d", ovr_cnt, exp_ovr); end
    @(posedge clk); #1;
    pl_ready = 1'b0;
    frm_ready = 1'b1;
    n = 0;
    while (!pl_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (pl_valid !== 1'b1) begin errors++; $display("FAIL pl_valid_wait got %b exp 1", pl_valid); end
    send_byte(8'h77);
    exp_ovr++;
    pl_ready = 1'b1;
    wait_drain(0);
    checks++;
    if (ovr_cnt !== exp_ovr) begin errors++; $display("FAIL ovr_total got %0d exp %0d", ovr_cnt, exp_ovr); end
  endtask

  task automatic test_back_to_back;
    int lens [4] = '{1, 16, 0, 5};
    int len;
    for (int f = 0; f < 7; f++) begin
      len = (f < 4) ? lens[f] : int'($urandom_range(0, 16));
      for (int j = 0; j < len; j++) pbuf[j] = 8'($urandom);
      send_frame(8'($urandom), 8'($urandom), 8'(len), 1'b0, 1'b1);
      wait_drain(1);
    end
    checks++;
    if ({err_csum_cnt, err_len_cnt, err_tmo_cnt, err_line_cnt, ovr_cnt} !==
        {exp_csum, exp_len, exp_tmo, exp_line, exp_ovr}) begin
      errors++;
      $display("FAIL b2b_counters got %h exp %h", {err_csum_cnt, err_len_cnt, err_tmo_cnt, err_line_cnt, ovr_cnt},
               {exp_csum, exp_len, exp_tmo, exp_line, exp_ovr});
    end
  endtask

  task automatic test_sat_clear;
    for (int k = 0; k < 260; k++) begin
      send_frame(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
      if (exp_csum != 8'hFF) exp_csum++;
      repeat (2) @(posedge clk); #1;
    end
    checks++;
    if (err_csum_cnt !== exp_csum) begin errors++; $display("FAIL csum_sat got %0d exp %0d", err_csum_cnt, exp_csum); end
    send_frame(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    {exp_csum, exp_len, exp_tmo, exp_line, exp_ovr} = '0;
    @(negedge clk);
    checks++;
    if ({err_csum_cnt, err_len_cnt, err_tmo_cnt, err_line_cnt, ovr_cnt} !== 40'd0) begin
      errors++;
      $display("FAIL clr_wins got %h exp 0", {err_csum_cnt, err_len_cnt, err_tmo_cnt, err_line_cnt, ovr_cnt});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int n = 0;
    frm_ready = 1'b1;
    pl_ready  = 1'b0;
    pbuf[0] = 8'hDE; pbuf[1] = 8'hAD; pbuf[2] = 8'hBE; pbuf[3] = 8'hEF;
    send_frame(8'h55, 8'h66, 8'h04, 1'b0, 1'b1);
    while (!pl_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (pl_valid !== 1'b1) begin errors++; $display("FAIL mid_pl_valid got %b exp 1", pl_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({frm_valid, pl_valid, pl_last, pl_data, frm_cmd, frm_addr, frm_len} !== '0) begin
      errors++;
      $display("FAIL async_reset got %b%b%b %h %h exp 0", frm_valid, pl_valid, pl_last, pl_data,
               {frm_cmd, frm_addr, frm_len});
    end
    hdr_q.delete(); pl_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    pl_ready = 1'b1;
    @(posedge clk); #1;
    send_frame(8'h01, 8'h02, 8'h00, 1'b0, 1'b1);
    wait_drain(0);
    checks++;
    if ({err_csum_cnt, err_len_cnt, err_tmo_cnt, err_line_cnt, ovr_cnt} !== 40'd0) begin
      errors++;
      $display("FAIL post_reset_counters got %h exp 0", {err_csum_cnt, err_len_cnt, err_tmo_cnt, err_line_cnt, ovr_cnt});
    end
  endtask

  initial begin
    rst_n = 1'b0; rx_byte_data = '0; rx_byte_valid = 1'b0;
    par_error = 1'b0; stop_error = 1'b0; frm_ready = 1'b1; pl_ready = 1'b1; clr_cnt = 1'b0;
    repeat (2) @(posedge clk); #1;
    test_reset();
    test_good_frame();
    test_zero_len();
    test_csum_len_err();
    test_line_err();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_sat_clear();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
